// File: rtl/chip8_timer_bank.sv
// chip8_timer_bank
//   Parametrised tick generator and CHIP-8 countdown register bank.
//   Each tick channel divides clk by a runtime-programmable divider and emits
//   a registered single-cycle strobe. The countdown registers (delay, sound)
//   decrement on the wrap of tick channel CD_SRC, saturate at zero and pulse
//   cd_expired on the 1->0 step.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_en    in   per-channel run enable
//   div_we     in   divider write strobe
//   div_sel    in   channel addressed by the divider write
//   div_wdata  in   new divider value (0 behaves as 1)
//   tick       out  registered one-cycle tick strobes
//   cd_we      in   countdown write strobe
//   cd_sel     in   countdown register addressed by the write
//   cd_wdata   in   countdown load value
//   cd_value   out  countdown values, register 0 in the LSBs
//   cd_active  out  combinational, value != 0 per register
//   cd_expired out  registered one-cycle pulse on a 1->0 decrement
module chip8_timer_bank #(
    parameter int NUM_TICKS     = 3,
    parameter int DIV_WIDTH     = 24,
    parameter logic [NUM_TICKS*DIV_WIDTH-1:0] DEFAULT_DIVS = {24'd50, 24'd833333, 24'd2},
    parameter int NUM_COUNTDOWN = 2,
    parameter int CNT_WIDTH     = 8,
    parameter int CD_SRC        = 1,
    localparam int DIV_SEL_W    = (NUM_TICKS > 1) ? $clog2(NUM_TICKS) : 1,
    localparam int CD_SEL_W     = (NUM_COUNTDOWN > 1) ? $clog2(NUM_COUNTDOWN) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_TICKS-1:0]               tick_en,
    input  logic                               div_we,
    input  logic [DIV_SEL_W-1:0]               div_sel,
    input  logic [DIV_WIDTH-1:0]               div_wdata,
    output logic [NUM_TICKS-1:0]               tick,
    input  logic                               cd_we,
    input  logic [CD_SEL_W-1:0]                cd_sel,
    input  logic [CNT_WIDTH-1:0]               cd_wdata,
    output logic [NUM_COUNTDOWN*CNT_WIDTH-1:0] cd_value,
    output logic [NUM_COUNTDOWN-1:0]           cd_active,
    output logic [NUM_COUNTDOWN-1:0]           cd_expired
);

    logic [DIV_WIDTH-1:0] div_q [NUM_TICKS];
    logic [DIV_WIDTH-1:0] cnt_q [NUM_TICKS];
    logic [DIV_WIDTH-1:0] eff   [NUM_TICKS];
    logic [NUM_TICKS-1:0] div_hit;
    logic [NUM_TICKS-1:0] wrap;
    logic [CNT_WIDTH-1:0] cd_q  [NUM_COUNTDOWN];
    logic                 dec;

    // A divider write to a channel takes priority over its wrap, so the wrap
    // (and hence the countdown decrement on CD_SRC) is masked on that edge.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        div_hit = '0;
        wrap    = '0;
        for (int i = 0; i < NUM_TICKS; i++) begin
            eff[i]     = (div_q[i] == '0) ? DIV_WIDTH'(1) : div_q[i];
            div_hit[i] = div_we && (int'(div_sel) == i);
            wrap[i]    = tick_en[i] && !div_hit[i] && (cnt_q[i] == eff[i] - DIV_WIDTH'(1));
        end
    end

    assign dec = wrap[CD_SRC];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the divider array is reset (not left uninitialised like a
            // RAM) because the channels must run at their defaults straight
            // out of reset.
            for (int i = 0; i < NUM_TICKS; i++) begin
                div_q[i] <= DEFAULT_DIVS[i*DIV_WIDTH +: DIV_WIDTH];
                cnt_q[i] <= '0;
            end
            tick <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            for (int i = 0; i < NUM_TICKS; i++) begin
                if (div_hit[i]) begin
                    div_q[i] <= div_wdata;
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (!tick_en[i]) begin
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (wrap[i]) begin
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b1;
                end else begin
                    cnt_q[i] <= cnt_q[i] + DIV_WIDTH'(1);
                    tick[i]  <= 1'b0;
                end
            end
        end
    end

    // Countdown registers: a host write wins over a simultaneous decrement,
    // and zero saturates so the sound buzzer never wraps back on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NUM_COUNTDOWN; j++) begin
                cd_q[j] <= '0;
            end
            cd_expired <= '0;
        end else begin
            for (int j = 0; j < NUM_COUNTDOWN; j++) begin
                if (cd_we && (int'(cd_sel) == j)) begin
                    cd_q[j]       <= cd_wdata;
                    cd_expired[j] <= 1'b0;
                end else if (dec && (cd_q[j] != '0)) begin
                    cd_q[j]       <= cd_q[j] - CNT_WIDTH'(1);
                    cd_expired[j] <= (cd_q[j] == CNT_WIDTH'(1));
                end else begin
                    cd_expired[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cd_value  = '0;
        cd_active = '0;
        for (int j = 0; j < NUM_COUNTDOWN; j++) begin
            cd_value[j*CNT_WIDTH +: CNT_WIDTH] = cd_q[j];
            cd_active[j]                       = (cd_q[j] != '0);
        end
    end

endmodule

// File: tb/tb_chip8_timer_bank.sv
// Self-checking bench for chip8_timer_bank. A behavioural model tracks, per
// channel, the number of enabled cycles since the last restart and ticks
// whenever that count is a multiple of the effective divider; countdowns are
// modelled as plain integers.
module tb_chip8_timer_bank;

    localparam int NT  = 3;
    localparam int DW  = 24;
    localparam int NC  = 2;
    localparam int CW  = 8;
    localparam int SRC = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NT-1:0]  tick_en;
    logic           div_we;
    logic [1:0]     div_sel;
    logic [DW-1:0]  div_wdata;
    logic [NT-1:0]  tick;
    logic           cd_we;
    logic [0:0]     cd_sel;
    logic [CW-1:0]  cd_wdata;
    logic [NC*CW-1:0] cd_value;
    logic [NC-1:0]  cd_active;
    logic [NC-1:0]  cd_expired;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int        div_m  [NT];
    int        since  [NT];
    logic [NT-1:0] tick_m;
    logic [7:0] cd_m  [NC];
    logic [NC-1:0] exp_m;

    // Expected tick pattern for cycles 1..6 after release with dividers 3,5,2
    logic [2:0] rel_pat [6] = '{3'b000, 3'b100, 3'b001, 3'b100, 3'b010, 3'b101};

    // Channel 0 is in the LSBs: ch0 = 3, ch1 = 5, ch2 = 2.
    chip8_timer_bank #(
        .NUM_TICKS    (NT),
        .DIV_WIDTH    (DW),
        .DEFAULT_DIVS ({24'd2, 24'd5, 24'd3}),
        .NUM_COUNTDOWN(NC),
        .CNT_WIDTH    (CW),
        .CD_SRC       (SRC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .div_we    (div_we),
        .div_sel   (div_sel),
        .div_wdata (div_wdata),
        .tick      (tick),
        .cd_we     (cd_we),
        .cd_sel    (cd_sel),
        .cd_wdata  (cd_wdata),
        .cd_value  (cd_value),
        .cd_active (cd_active),
        .cd_expired(cd_expired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        div_m[0] = 3;
        div_m[1] = 5;
        div_m[2] = 2;
        for (int i = 0; i < NT; i++) since[i] = 0;
        for (int j = 0; j < NC; j++) cd_m[j] = 8'd0;
        tick_m = '0;
        exp_m  = '0;
    endtask

    // Apply one rising edge to the model using the inputs present at the edge.
    task automatic model_edge();
        logic [NT-1:0] nt;
        logic          dec_m;
        int            e;
        nt = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NT; i++) begin
            e = (div_m[i] == 0) ? 1 : div_m[i];
            if (div_we && int'(div_sel) == i) begin
                div_m[i] = int'(div_wdata);
                since[i] = 0;
            end else if (!tick_en[i]) begin
                since[i] = 0;
            end else begin
                since[i] = since[i] + 1;
                nt[i]    = ((since[i] % e) == 0);
            end
        end
        dec_m = nt[SRC];
        for (int j = 0; j < NC; j++) begin
            exp_m[j] = 1'b0;
            if (cd_we && int'(cd_sel) == j) begin
                cd_m[j] = cd_wdata;
            end else if (dec_m && cd_m[j] != 0) begin
                cd_m[j]  = cd_m[j] - 8'd1;
                exp_m[j] = (cd_m[j] == 0);
            end
        end
        tick_m = nt;
    endtask

    // True when the next edge decrements, assuming no divider write on it.
    function automatic bit dec_next();
        int e;
        e = (div_m[SRC] == 0) ? 1 : div_m[SRC];
        return tick_en[SRC] && (((since[SRC] + 1) % e) == 0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_tick"}, 32'(tick), 32'(tick_m));
        chk({tag, "_cd_value"}, 32'(cd_value), 32'({cd_m[1], cd_m[0]}));
        chk({tag, "_cd_active"}, 32'(cd_active), 32'({cd_m[1] != 0, cd_m[0] != 0}));
        chk({tag, "_cd_expired"}, 32'(cd_expired), 32'(exp_m));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
        chk({tag, "_cd_value"}, 32'(cd_value), 32'd0);
        chk({tag, "_cd_active"}, 32'(cd_active), 32'd0);
        chk({tag, "_cd_expired"}, 32'(cd_expired), 32'd0);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic idle();
        div_we = 1'b0;
        cd_we  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        tick_en   = '1;
        div_we    = 1'b0;
        div_sel   = '0;
        div_wdata = '0;
        cd_we     = 1'b0;
        cd_sel    = '0;
        cd_wdata  = '0;
        model_reset();

        // Reset held: no ticks, everything zero
        #1 check_zero("reset");
        repeat (3) begin
            cycle();
            check_zero("reset_hold");
        end

        // Release on a falling edge; defaults 3,5,2
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("release_pattern", 32'(tick), 32'(rel_pat[k]));
        end
        repeat (8) cycle();

        // Channel 1 div=4, then rewrite to 6 two cycles after a tick
        div_we = 1'b1; div_sel = 2'd1; div_wdata = 24'd4;
        cycle();
        idle();
        for (int k = 0; k < 16 && !tick_m[1]; k++) cycle();
        cycle();
        div_we = 1'b1; div_sel = 2'd1; div_wdata = 24'd6;
        cycle();
        idle();
        for (int r = 0; r < 2; r++) begin
            repeat (5) begin
                cycle();
                chk("div6_gap", 32'(tick[1]), 32'd0);
            end
            cycle();
            chk("div6_tick", 32'(tick[1]), 32'd1);
        end

        // Divider write landing on the wrap edge: no tick, no decrement
        cd_we = 1'b1; cd_sel = 1'b1; cd_wdata = 8'd3;
        cycle();
        idle();
        for (int k = 0; k < 16 && !dec_next(); k++) cycle();
        div_we = 1'b1; div_sel = 2'd1; div_wdata = 24'd6;
        cycle();
        idle();
        chk("wr_on_wrap_tick", 32'(tick[1]), 32'd0);
        chk("wr_on_wrap_sound", 32'(cd_value[15:8]), 32'd3);

        // Out-of-range divider select is ignored
        div_we = 1'b1; div_sel = 2'd3; div_wdata = 24'd1;
        cycle();
        idle();
        repeat (8) cycle();

        // Divider 0 on channel 0 behaves as 1: tick held high
        div_we = 1'b1; div_sel = 2'd0; div_wdata = 24'd0;
        cycle();
        idle();
        repeat (5) begin
            cycle();
            chk("div0_const", 32'(tick[0]), 32'd1);
        end

        // Gate channel 0 mid-period, then re-enable
        div_we = 1'b1; div_sel = 2'd0; div_wdata = 24'd3;
        cycle();
        idle();
        cycle();
        tick_en[0] = 1'b0;
        cycle();
        chk("gated_tick0", 32'(tick[0]), 32'd0);
        cycle();
        tick_en[0] = 1'b1;
        repeat (2) begin
            cycle();
            chk("reenable_gap", 32'(tick[0]), 32'd0);
        end
        cycle();
        chk("reenable_tick", 32'(tick[0]), 32'd1);

        // Countdown: CD_SRC div=2, delay=3 counts down and saturates
        div_we = 1'b1; div_sel = 2'd1; div_wdata = 24'd2;
        cd_we  = 1'b1; cd_sel = 1'b0; cd_wdata = 8'd3;
        cycle();
        idle();
        repeat (12) cycle();
        chk("delay_saturated", 32'(cd_value[7:0]), 32'd0);

        // Write wins over a simultaneous decrement
        cd_we = 1'b1; cd_sel = 1'b1; cd_wdata = 8'd2;
        cycle();
        idle();
        for (int k = 0; k < 8 && !dec_next(); k++) cycle();
        cd_we = 1'b1; cd_sel = 1'b1; cd_wdata = 8'd5;
        cycle();
        idle();
        chk("write_wins_value", 32'(cd_value[15:8]), 32'd5);
        chk("write_wins_expired", 32'(cd_expired), 32'd0);

        // Writing 0 never pulses expired
        cd_we = 1'b1; cd_sel = 1'b1; cd_wdata = 8'd1;
        cycle();
        cd_wdata = 8'd0;
        cycle();
        idle();
        chk("write0_value", 32'(cd_value[15:8]), 32'd0);
        chk("write0_expired", 32'(cd_expired[1]), 32'd0);

        // Asynchronous reset between edges with delay=7 loaded
        cd_we = 1'b1; cd_sel = 1'b0; cd_wdata = 8'd7;
        cycle();
        idle();
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_zero("async_reset");
        repeat (2) begin
            cycle();
            check_zero("async_hold");
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rerelease_pattern", 32'(tick), 32'(rel_pat[k]));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            tick_en   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
            div_we    = ($urandom_range(0, 7) == 0);
            div_sel   = 2'($urandom);
            div_wdata = 24'($urandom_range(0, 6));
            cd_we     = ($urandom_range(0, 9) == 0);
            cd_sel    = 1'($urandom);
            cd_wdata  = 8'($urandom_range(0, 4));
            cycle();
        end
        idle();
        tick_en = '1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_timer_bank.md
Name: chip8_timer_bank

Overview:
- Parametrised successor to the fixed three-output CHIP-8 timer.
- Generates NUM_TICKS independent single-cycle tick strobes from clk, e.g. CPU cycle, 60 Hz and VGA pixel ticks.
- Dividers are loaded from parameters at reset and can be reprogrammed and gated at runtime.
- Also holds NUM_COUNTDOWN 8-bit CHIP-8 countdown registers (delay and sound). These decrement on a selected tick channel and flag expiry. The block feeds cpu, gpu and VGA logic.

Parameters:
- NUM_TICKS, 3, number of tick channels (≥1).
- DIV_WIDTH, 24, divider and counter width per channel.
- DEFAULT_DIVS, {24'd50, 24'd833333, 24'd2}, packed NUM_TICKS*DIV_WIDTH reset dividers; channel 0 is in the LSBs.
- NUM_COUNTDOWN, 2, number of countdown registers (0 = delay, 1 = sound).
- CNT_WIDTH, 8, countdown register width.
- CD_SRC, 1, index of the tick channel that decrements countdowns.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick_en  in  NUM_TICKS  per-channel run enable.
- div_we  in  1  divider write strobe.
- div_sel  in  clog2(NUM_TICKS) (min 1)  channel selected for the divider write.
- div_wdata  in  DIV_WIDTH  new divider value.
- tick  out  NUM_TICKS  registered one-cycle tick strobes.
- cd_we  in  1  countdown write strobe.
- cd_sel  in  clog2(NUM_COUNTDOWN) (min 1)  countdown register selected for the write.
- cd_wdata  in  CNT_WIDTH  countdown load value.
- cd_value  out  NUM_COUNTDOWN*CNT_WIDTH  current countdown values, register 0 in the LSBs.
- cd_active  out  NUM_COUNTDOWN  combinational, value != 0 (sound buzzer enable).
- cd_expired  out  NUM_COUNTDOWN  registered one-cycle pulse on a 1→0 decrement.

Behaviour:
- Reset (rst_n low, asynchronous):
  - div[i] = DEFAULT_DIVS slice, cnt[i] = 0, tick = 0.
  - cd_value = 0, cd_expired = 0, cd_active = 0.
  - Reset mid-period discards all progress; no tick is emitted on release.
- Effective divider: eff[i] = (div[i]==0) ? 1 : div[i].
- Per channel, each edge:
  - tick_en[i] low: cnt <= 0, tick[i] <= 0.
  - Else if cnt == eff-1: cnt <= 0, tick[i] <= 1.
  - Else: cnt <= cnt+1, tick[i] <= 0.
- Tick timing:
  - Period is exactly eff cycles.
  - The first tick is high in the cycle after the eff-th enabled edge.
  - eff = 1 gives tick[i] held high continuously.
- Divider write (div_we, div_sel < NUM_TICKS):
  - div[sel] <= div_wdata and cnt[sel] <= 0 on the same edge.
  - tick[sel] <= 0 on that edge, even if a wrap was due.
  - The new period counts from that edge.
  - div_sel ≥ NUM_TICKS: the write is ignored.
  - Other channels are unaffected.
- Decrement event: "dec" = the wrap condition of channel CD_SRC on this edge, i.e. the same edge that sets tick[CD_SRC]. The new value is therefore visible in the cycle tick[CD_SRC] is high.
- Countdown register j, each edge, in priority order:
  1. cd_we && cd_sel==j: value <= cd_wdata, expired[j] <= 0. The write wins over a simultaneous dec, and writing 0 never pulses expired.
  2. Else if dec && value != 0: value <= value-1; expired[j] <= (value==1).
  3. Else: hold, expired[j] <= 0.
- Countdown boundaries:
  - A value of 0 saturates; there is no wrap to 255.
  - cd_sel ≥ NUM_COUNTDOWN: the write is ignored.
- Width rules: counters compare at DIV_WIDTH with no overflow possible, since cnt < eff ≤ 2^DIV_WIDTH-1. Countdown arithmetic is unsigned CNT_WIDTH.
- Simultaneous events:
  - A divider write to CD_SRC suppresses dec on that edge.
  - tick_en[CD_SRC] low means no decrements; values hold.

Test Plan:
- Reset release, defaults with DEFAULT_DIVS overridden to {3,5,2}, all tick_en=1 → tick[0] high at cycles 3,6,9; tick[1] at 5,10; tick[2] at 2,4,6. No tick during reset.
- Channel 1 div=4 running; at cycle 2 after its last tick write div_sel=1, div_wdata=6 → no tick at the old slot; next tick exactly 6 cycles after the write edge, then every 6.
- div_wdata=0 on channel 0 → tick[0] constant 1. tick_en[0]=0 mid-period → tick[0]=0 next cycle; re-enable → first tick after a full eff cycles.
- CD_SRC div=2, load delay=3 → cd_value[0] 3→2→1→0 on successive tick[1] cycles; cd_expired[0] high only in the cycle the value becomes 0; cd_active[0] drops the same cycle; it stays 0 on later ticks.
- cd_we to sound=5 on the same edge as dec with sound=2 → sound=5, no decrement, no expired pulse. Writing 0 while at 1 → value 0, cd_expired=0.
- Assert rst_n low asynchronously mid-count (between clk edges) with delay=7 → all outputs 0 immediately; after release, tick[i] first appears exactly eff cycles later.
